memory_4r_1w: RTL and testbench

MEMORY_4R_1W -- requirements
Module: memory_4r_1w

---
 rtl/memory_4r_1w.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_memory_4r_1w.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_4r_1w.sv
`default_nettype none
// ============================================================================
//  Module   : memory_4r_1w (with helper memory_4r_1w_dpram)
//  Purpose  : Four-read / one-write memory built from four replicated banks.
//             Read port N is served only by bank N, so all four read ports
//             run concurrently with one-cycle latency. Every write goes to all
//             four banks, which keeps them identical. While enable is low the
//             links stall and a host port reads bank 0 and writes all banks.
//  Ports    : clock, reset              - rising-edge clock, sync active-high
//             enable                    - 1: serve links, 0: serve host
//             host_interface_*          - 4-phase read/write host access
//             read_index_N_input_link_* - read index in  (req/ack/tag/data)
//             read_data_N_output_link_* - read result out (req/ack/tag/data)
//             write_index_input_link_*  - write address in
//             write_data_input_link_*   - write value in
//             quiescent                 - nothing pending or in flight
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One bank: port A is a registered read; port B writes and can also do a
// registered read (bank 0 serves host reads there). Both reads are
// read-first: a same-edge write to the same address returns the old word.
// The array is never reset, so preloaded contents survive reset.
// ----------------------------------------------------------------------------
module memory_4r_1w_dpram #(
    parameter int DEPTH = 32768,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_a_en,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic             b_we,
    input  logic             b_re,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clock) begin
        if (b_we) begin
            ram[b_addr] <= b_wdata;
        end
    end

    // Port A register doubles as the read port's output data register; it
    // only loads when an index is accepted, so it holds while stalled.
    always_ff @(posedge clock) begin
        if (rd_a_en) begin
            rd_a_data <= ram[rd_a_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b_rdata <= '0;
        end else if (b_re) begin
            b_rdata <= ram[b_addr];
        end
    end

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module memory_4r_1w #(
    parameter int DEPTH      = 32768,
    parameter int WORD_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,

    input  logic                  host_interface_read_req,
    input  logic [WORD_WIDTH-1:0] host_interface_read_index,
    output logic                  host_interface_read_ack,
    output logic [WORD_WIDTH-1:0] host_interface_read_data,
    input  logic                  host_interface_write_req,
    input  logic [WORD_WIDTH-1:0] host_interface_write_index,
    input  logic [WORD_WIDTH-1:0] host_interface_write_data,
    output logic                  host_interface_write_ack,

    input  logic                  read_index_0_input_link_req,
    output logic                  read_index_0_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  read_index_0_input_link_tag,
    input  logic [WORD_WIDTH-1:0] read_index_0_input_link_data,
    input  logic                  read_index_1_input_link_req,
    output logic                  read_index_1_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  read_index_1_input_link_tag,
    input  logic [WORD_WIDTH-1:0] read_index_1_input_link_data,
    input  logic                  read_index_2_input_link_req,
    output logic                  read_index_2_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  read_index_2_input_link_tag,
    input  logic [WORD_WIDTH-1:0] read_index_2_input_link_data,
    input  logic                  read_index_3_input_link_req,
    output logic                  read_index_3_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  read_index_3_input_link_tag,
    input  logic [WORD_WIDTH-1:0] read_index_3_input_link_data,

    output logic                  read_data_0_output_link_req,
    input  logic                  read_data_0_output_link_ack,
    output logic [TAG_WIDTH-1:0]  read_data_0_output_link_tag,
    output logic [WORD_WIDTH-1:0] read_data_0_output_link_data,
    output logic                  read_data_1_output_link_req,
    input  logic                  read_data_1_output_link_ack,
    output logic [TAG_WIDTH-1:0]  read_data_1_output_link_tag,
    output logic [WORD_WIDTH-1:0] read_data_1_output_link_data,
    output logic                  read_data_2_output_link_req,
    input  logic                  read_data_2_output_link_ack,
    output logic [TAG_WIDTH-1:0]  read_data_2_output_link_tag,
    output logic [WORD_WIDTH-1:0] read_data_2_output_link_data,
    output logic                  read_data_3_output_link_req,
    input  logic                  read_data_3_output_link_ack,
    output logic [TAG_WIDTH-1:0]  read_data_3_output_link_tag,
    output logic [WORD_WIDTH-1:0] read_data_3_output_link_data,

    input  logic                  write_index_input_link_req,
    output logic                  write_index_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  write_index_input_link_tag,
    input  logic [WORD_WIDTH-1:0] write_index_input_link_data,
    input  logic                  write_data_input_link_req,
    output logic                  write_data_input_link_ack,
    input  logic [TAG_WIDTH-1:0]  write_data_input_link_tag,
    input  logic [WORD_WIDTH-1:0] write_data_input_link_data,

    output logic                  quiescent
);

    // DEPTH is a power of two >= 2; the low AW index bits give index mod DEPTH.
    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Gather the per-port link signals into arrays
    // ------------------------------------------------------------------
    logic                  w_ri_req  [4];
    logic                  w_ri_ack  [4];
    logic [TAG_WIDTH-1:0]  w_ri_tag  [4];
    logic [WORD_WIDTH-1:0] w_ri_data [4];
    logic                  w_ro_ack  [4];
    logic [WORD_WIDTH-1:0] w_ro_data [4];
    logic                  r_ro_valid [4];
    logic [TAG_WIDTH-1:0]  r_ro_tag   [4];
    logic                  w_ri_xfer [4];
    logic                  w_ro_xfer [4];

    assign w_ri_req[0]  = read_index_0_input_link_req;
    assign w_ri_req[1]  = read_index_1_input_link_req;
    assign w_ri_req[2]  = read_index_2_input_link_req;
    assign w_ri_req[3]  = read_index_3_input_link_req;
    assign w_ri_tag[0]  = read_index_0_input_link_tag;
    assign w_ri_tag[1]  = read_index_1_input_link_tag;
    assign w_ri_tag[2]  = read_index_2_input_link_tag;
    assign w_ri_tag[3]  = read_index_3_input_link_tag;
    assign w_ri_data[0] = read_index_0_input_link_data;
    assign w_ri_data[1] = read_index_1_input_link_data;
    assign w_ri_data[2] = read_index_2_input_link_data;
    assign w_ri_data[3] = read_index_3_input_link_data;
    assign w_ro_ack[0]  = read_data_0_output_link_ack;
    assign w_ro_ack[1]  = read_data_1_output_link_ack;
    assign w_ro_ack[2]  = read_data_2_output_link_ack;
    assign w_ro_ack[3]  = read_data_3_output_link_ack;

    assign read_index_0_input_link_ack  = w_ri_ack[0];
    assign read_index_1_input_link_ack  = w_ri_ack[1];
    assign read_index_2_input_link_ack  = w_ri_ack[2];
    assign read_index_3_input_link_ack  = w_ri_ack[3];
    assign read_data_0_output_link_req  = r_ro_valid[0];
    assign read_data_1_output_link_req  = r_ro_valid[1];
    assign read_data_2_output_link_req  = r_ro_valid[2];
    assign read_data_3_output_link_req  = r_ro_valid[3];
    assign read_data_0_output_link_tag  = r_ro_tag[0];
    assign read_data_1_output_link_tag  = r_ro_tag[1];
    assign read_data_2_output_link_tag  = r_ro_tag[2];
    assign read_data_3_output_link_tag  = r_ro_tag[3];
    assign read_data_0_output_link_data = w_ro_data[0];
    assign read_data_1_output_link_data = w_ro_data[1];
    assign read_data_2_output_link_data = w_ro_data[2];
    assign read_data_3_output_link_data = w_ro_data[3];

    // ------------------------------------------------------------------
    // Read port control: one output register per port. Acks are held low
    // during reset so nothing is accepted and then silently lost.
    // ------------------------------------------------------------------
    generate
        for (genvar n = 0; n < 4; n++) begin : g_read_port
            assign w_ri_ack[n]  = enable && !reset && (!r_ro_valid[n] || w_ro_ack[n]);
            assign w_ri_xfer[n] = w_ri_req[n] && w_ri_ack[n];
            // With enable low the port is frozen, so the output register
            // is not drained even if the receiver acks.
            assign w_ro_xfer[n] = enable && r_ro_valid[n] && w_ro_ack[n];

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_ro_valid[n] <= 1'b0;
                    r_ro_tag[n]   <= '0;
                end else if (w_ri_xfer[n]) begin
                    r_ro_valid[n] <= 1'b1;
                    r_ro_tag[n]   <= w_ri_tag[n];
                end else if (w_ro_xfer[n]) begin
                    r_ro_valid[n] <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Link write: index and data are consumed together or not at all.
    // ------------------------------------------------------------------
    logic w_link_we;
    assign w_link_we = enable && !reset && write_index_input_link_req
                       && write_data_input_link_req;
    assign write_index_input_link_ack = w_link_we;
    assign write_data_input_link_ack  = w_link_we;

    // ------------------------------------------------------------------
    // Host access (enable low only). A new request starts only when both
    // acks are low, so each request is served exactly once; write wins.
    // ------------------------------------------------------------------
    logic r_host_write_ack;
    logic r_host_read_ack;
    logic w_host_idle;
    logic w_host_we;
    logic w_host_re;

    assign w_host_idle = !r_host_write_ack && !r_host_read_ack;
    assign w_host_we   = !enable && !reset && w_host_idle && host_interface_write_req;
    assign w_host_re   = !enable && !reset && w_host_idle && host_interface_read_req
                         && !host_interface_write_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_host_write_ack <= 1'b0;
        end else if (w_host_we) begin
            r_host_write_ack <= 1'b1;
        end else if (!host_interface_write_req) begin
            r_host_write_ack <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_host_read_ack <= 1'b0;
        end else if (w_host_re) begin
            r_host_read_ack <= 1'b1;
        end else if (!host_interface_read_req) begin
            r_host_read_ack <= 1'b0;
        end
    end

    assign host_interface_write_ack = r_host_write_ack;
    assign host_interface_read_ack  = r_host_read_ack;

    // ------------------------------------------------------------------
    // Shared port B: link write when enabled, host access otherwise.
    // ------------------------------------------------------------------
    logic                  w_b_we;
    logic [AW-1:0]         w_b_addr;
    logic [WORD_WIDTH-1:0] w_b_wdata;

    assign w_b_we    = w_link_we || w_host_we;
    assign w_b_addr  = enable                   ? write_index_input_link_data[AW-1:0] :
                       host_interface_write_req ? host_interface_write_index[AW-1:0]  :
                                                  host_interface_read_index[AW-1:0];
    assign w_b_wdata = enable ? write_data_input_link_data : host_interface_write_data;

    logic [WORD_WIDTH-1:0] w_unused_rdb1;
    logic [WORD_WIDTH-1:0] w_unused_rdb2;
    logic [WORD_WIDTH-1:0] w_unused_rdb3;

    memory_4r_1w_dpram #(.DEPTH(DEPTH), .WIDTH(WORD_WIDTH), .AW(AW)) dpram0 (
        .clock(clock), .reset(reset),
        .rd_a_en(w_ri_xfer[0]), .rd_a_addr(w_ri_data[0][AW-1:0]), .rd_a_data(w_ro_data[0]),
        .b_we(w_b_we), .b_re(w_host_re), .b_addr(w_b_addr), .b_wdata(w_b_wdata),
        .b_rdata(host_interface_read_data)
    );

    memory_4r_1w_dpram #(.DEPTH(DEPTH), .WIDTH(WORD_WIDTH), .AW(AW)) dpram1 (
        .clock(clock), .reset(reset),
        .rd_a_en(w_ri_xfer[1]), .rd_a_addr(w_ri_data[1][AW-1:0]), .rd_a_data(w_ro_data[1]),
        .b_we(w_b_we), .b_re(1'b0), .b_addr(w_b_addr), .b_wdata(w_b_wdata),
        .b_rdata(w_unused_rdb1)
    );

    memory_4r_1w_dpram #(.DEPTH(DEPTH), .WIDTH(WORD_WIDTH), .AW(AW)) dpram2 (
        .clock(clock), .reset(reset),
        .rd_a_en(w_ri_xfer[2]), .rd_a_addr(w_ri_data[2][AW-1:0]), .rd_a_data(w_ro_data[2]),
        .b_we(w_b_we), .b_re(1'b0), .b_addr(w_b_addr), .b_wdata(w_b_wdata),
        .b_rdata(w_unused_rdb2)
    );

    memory_4r_1w_dpram #(.DEPTH(DEPTH), .WIDTH(WORD_WIDTH), .AW(AW)) dpram3 (
        .clock(clock), .reset(reset),
        .rd_a_en(w_ri_xfer[3]), .rd_a_addr(w_ri_data[3][AW-1:0]), .rd_a_data(w_ro_data[3]),
        .b_we(w_b_we), .b_re(1'b0), .b_addr(w_b_addr), .b_wdata(w_b_wdata),
        .b_rdata(w_unused_rdb3)
    );

    // Index bits above AW (wrap) and write-link tags carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{write_index_input_link_tag, write_data_input_link_tag,
                             write_index_input_link_data, host_interface_write_index,
                             host_interface_read_index, w_ri_data[0], w_ri_data[1],
                             w_ri_data[2], w_ri_data[3]};

    // ------------------------------------------------------------------
    // Quiescent: no result held and no input link requesting.
    // ------------------------------------------------------------------
    assign quiescent = !(r_ro_valid[0] || r_ro_valid[1] || r_ro_valid[2] || r_ro_valid[3])
                       && !(w_ri_req[0] || w_ri_req[1] || w_ri_req[2] || w_ri_req[3])
                       && !write_index_input_link_req && !write_data_input_link_req;

endmodule
`default_nettype wire

// File: tb/tb_memory_4r_1w.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_4r_1w
//  Purpose  : Directed self-checking bench for memory_4r_1w (DEPTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_4r_1w;

    localparam int DEPTH = 16;
    localparam int WW    = 32;
    localparam int TW    = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          enable;
    logic          h_rreq, h_rack, h_wreq, h_wack;
    logic [WW-1:0] h_ridx, h_rdata, h_widx, h_wdata;
    logic          ri_req  [4];
    logic          ri_ack  [4];
    logic [TW-1:0] ri_tag  [4];
    logic [WW-1:0] ri_data [4];
    logic          ro_req  [4];
    logic          ro_ack  [4];
    logic [TW-1:0] ro_tag  [4];
    logic [WW-1:0] ro_data [4];
    logic          wi_req, wi_ack, wd_req, wd_ack;
    logic [TW-1:0] wi_tag, wd_tag;
    logic [WW-1:0] wi_data, wd_data;
    logic          quiescent;

    memory_4r_1w #(.DEPTH(DEPTH), .WORD_WIDTH(WW), .TAG_WIDTH(TW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .host_interface_read_req(h_rreq), .host_interface_read_index(h_ridx),
        .host_interface_read_ack(h_rack), .host_interface_read_data(h_rdata),
        .host_interface_write_req(h_wreq), .host_interface_write_index(h_widx),
        .host_interface_write_data(h_wdata), .host_interface_write_ack(h_wack),
        .read_index_0_input_link_req(ri_req[0]), .read_index_0_input_link_ack(ri_ack[0]),
        .read_index_0_input_link_tag(ri_tag[0]), .read_index_0_input_link_data(ri_data[0]),
        .read_index_1_input_link_req(ri_req[1]), .read_index_1_input_link_ack(ri_ack[1]),
        .read_index_1_input_link_tag(ri_tag[1]), .read_index_1_input_link_data(ri_data[1]),
        .read_index_2_input_link_req(ri_req[2]), .read_index_2_input_link_ack(ri_ack[2]),
        .read_index_2_input_link_tag(ri_tag[2]), .read_index_2_input_link_data(ri_data[2]),
        .read_index_3_input_link_req(ri_req[3]), .read_index_3_input_link_ack(ri_ack[3]),
        .read_index_3_input_link_tag(ri_tag[3]), .read_index_3_input_link_data(ri_data[3]),
        .read_data_0_output_link_req(ro_req[0]), .read_data_0_output_link_ack(ro_ack[0]),
        .read_data_0_output_link_tag(ro_tag[0]), .read_data_0_output_link_data(ro_data[0]),
        .read_data_1_output_link_req(ro_req[1]), .read_data_1_output_link_ack(ro_ack[1]),
        .read_data_1_output_link_tag(ro_tag[1]), .read_data_1_output_link_data(ro_data[1]),
        .read_data_2_output_link_req(ro_req[2]), .read_data_2_output_link_ack(ro_ack[2]),
        .read_data_2_output_link_tag(ro_tag[2]), .read_data_2_output_link_data(ro_data[2]),
        .read_data_3_output_link_req(ro_req[3]), .read_data_3_output_link_ack(ro_ack[3]),
        .read_data_3_output_link_tag(ro_tag[3]), .read_data_3_output_link_data(ro_data[3]),
        .write_index_input_link_req(wi_req), .write_index_input_link_ack(wi_ack),
        .write_index_input_link_tag(wi_tag), .write_index_input_link_data(wi_data),
        .write_data_input_link_req(wd_req), .write_data_input_link_ack(wd_ack),
        .write_data_input_link_tag(wd_tag), .write_data_input_link_data(wd_data),
        .quiescent(quiescent)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled then too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    typedef struct {
        int          port;
        logic [WW-1:0] idx;
        logic [TW-1:0] tag;
        logic [WW-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Banks preloaded with ram[i] = i, so a read of idx returns idx mod 16.
        vecs[0] = '{2, 32'd5,  3'd1, 32'd5};
        vecs[1] = '{0, 32'd0,  3'd7, 32'd0};
        vecs[2] = '{1, 32'd15, 3'd2, 32'd15};
        vecs[3] = '{3, 32'd20, 3'd3, 32'd4};    // DEPTH+4 wraps to 4
        vecs[4] = '{0, 32'd31, 3'd4, 32'd15};
        vecs[5] = '{1, 32'd16, 3'd5, 32'd0};
        vecs[6] = '{3, 32'd10, 3'd6, 32'd10};

        for (int i = 0; i < DEPTH; i++) begin
            dut.dpram0.ram[i] = 32'(i);
            dut.dpram1.ram[i] = 32'(i);
            dut.dpram2.ram[i] = 32'(i);
            dut.dpram3.ram[i] = 32'(i);
        end

        reset = 1'b1; enable = 1'b0;
        h_rreq = 0; h_wreq = 0; h_ridx = '0; h_widx = '0; h_wdata = '0;
        wi_req = 0; wd_req = 0; wi_tag = '0; wd_tag = '0; wi_data = '0; wd_data = '0;
        for (int p = 0; p < 4; p++) begin
            ri_req[p] = 0; ri_tag[p] = '0; ri_data[p] = '0; ro_ack[p] = 1'b1;
        end
        tick(); tick();
        reset = 1'b0;
        settle();

        // ---------------- reset state ----------------
        for (int p = 0; p < 4; p++) check($sformatf("rst_valid%0d", p), 32'(ro_req[p]), 32'd0);
        check("rst_read_ack", 32'(h_rack), 32'd0);
        check("rst_write_ack", 32'(h_wack), 32'd0);
        check("rst_read_data", h_rdata, 32'd0);
        check("rst_quiescent", 32'(quiescent), 32'd1);

        // ---------------- table-driven single reads ----------------
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ri_req[vecs[i].port]  = 1'b1;
            ri_tag[vecs[i].port]  = vecs[i].tag;
            ri_data[vecs[i].port] = vecs[i].idx;
            settle();
            check($sformatf("vec%0d_iack", i), 32'(ri_ack[vecs[i].port]), 32'd1);
            tick();
            ri_req[vecs[i].port] = 1'b0;
            check($sformatf("vec%0d_req", i), 32'(ro_req[vecs[i].port]), 32'd1);
            check($sformatf("vec%0d_data", i), ro_data[vecs[i].port], vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 32'(ro_tag[vecs[i].port]), 32'(vecs[i].tag));
            tick();
            check($sformatf("vec%0d_drain", i), 32'(ro_req[vecs[i].port]), 32'd0);
        end

        // ---------------- link write, broadcast to all banks ----------------
        wi_req = 1; wi_data = 32'd7; wd_req = 1; wd_data = 32'hDEAD;
        settle();
        check("wr_idx_ack", 32'(wi_ack), 32'd1);
        check("wr_dat_ack", 32'(wd_ack), 32'd1);
        tick();
        wi_req = 0; wd_req = 0;
        for (int p = 0; p < 4; p++) begin
            ri_req[p] = 1; ri_data[p] = 32'd7; ri_tag[p] = 3'(p);
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            ri_req[p] = 0;
            check($sformatf("bcast_data%0d", p), ro_data[p], 32'hDEAD);
            check($sformatf("bcast_tag%0d", p), 32'(ro_tag[p]), 32'(p));
        end
        tick();

        // ---------------- write index alone is not consumed ----------------
        wi_req = 1; wi_data = 32'd9; wd_data = 32'h1234;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("alone_idx_ack%0d", c), 32'(wi_ack), 32'd0);
            check($sformatf("alone_dat_ack%0d", c), 32'(wd_ack), 32'd0);
            tick();
        end
        ri_req[1] = 1; ri_data[1] = 32'd9; ri_tag[1] = 3'd0;
        tick();
        ri_req[1] = 0;
        check("alone_unchanged", ro_data[1], 32'd9);
        wd_req = 1;
        settle();
        check("pair_ack", 32'(wi_ack & wd_ack), 32'd1);
        tick();
        wi_req = 0; wd_req = 0;
        ri_req[1] = 1;
        tick();
        ri_req[1] = 0;
        check("pair_written", ro_data[1], 32'h1234);
        tick();

        // ---------------- read-first on same-cycle collision ----------------
        wi_req = 1; wi_data = 32'd9; wd_req = 1; wd_data = 32'hBEEF;
        ri_req[0] = 1; ri_data[0] = 32'd9; ri_tag[0] = 3'd1;
        tick();
        wi_req = 0; wd_req = 0;
        check("collide_old", ro_data[0], 32'h1234);
        tick();
        ri_req[0] = 0;
        check("collide_new", ro_data[0], 32'hBEEF);
        tick();

        // ---------------- output stall on port 0 ----------------
        ro_ack[0] = 0;
        ri_req[0] = 1; ri_data[0] = 32'd1; ri_tag[0] = 3'd1;
        tick();
        ri_data[0] = 32'd2; ri_tag[0] = 3'd2;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("stall_iack%0d", c), 32'(ri_ack[0]), 32'd0);
            check($sformatf("stall_data%0d", c), ro_data[0], 32'd1);
            check($sformatf("stall_tag%0d", c), 32'(ro_tag[0]), 32'd1);
            tick();
        end
        ro_ack[0] = 1;
        settle();
        check("unstall_iack", 32'(ri_ack[0]), 32'd1);
        tick();
        check("unstall_d2", ro_data[0], 32'd2);
        check("unstall_t2", 32'(ro_tag[0]), 32'd2);
        ri_data[0] = 32'd3; ri_tag[0] = 3'd3;
        tick();
        ri_req[0] = 0;
        check("unstall_d3", ro_data[0], 32'd3);
        check("unstall_t3", 32'(ro_tag[0]), 32'd3);
        tick();
        check("unstall_drain", 32'(ro_req[0]), 32'd0);

        // ---------------- host access with enable low ----------------
        enable = 0;
        ri_req[0] = 1; ri_data[0] = 32'd3;
        wi_req = 1; wd_req = 1; wi_data = 32'd3; wd_data = 32'hAAAA;
        h_wreq = 1; h_widx = 32'd3; h_wdata = 32'h55;
        settle();
        check("host_link_iack", 32'(ri_ack[0]), 32'd0);
        check("host_link_wack", 32'(wi_ack | wd_ack), 32'd0);
        tick();
        check("host_wack", 32'(h_wack), 32'd1);
        tick();
        check("host_wack_held", 32'(h_wack), 32'd1);
        h_wreq = 0;
        tick();
        check("host_wack_low", 32'(h_wack), 32'd0);
        h_rreq = 1; h_ridx = 32'd3;
        tick();
        check("host_rack", 32'(h_rack), 32'd1);
        check("host_rdata", h_rdata, 32'h55);
        tick();
        check("host_rack_held", 32'(h_rack), 32'd1);
        h_rreq = 0;
        tick();
        check("host_rack_low", 32'(h_rack), 32'd0);
        // Write and read requested together: write first, read after.
        h_wreq = 1; h_widx = 32'd20; h_wdata = 32'h66; h_rreq = 1; h_ridx = 32'd4;
        tick();
        check("prio_wack", 32'(h_wack), 32'd1);
        check("prio_rack", 32'(h_rack), 32'd0);
        h_wreq = 0;
        tick();
        tick();
        check("prio_rack_late", 32'(h_rack), 32'd1);
        check("prio_rdata", h_rdata, 32'h66);
        h_rreq = 0;
        ri_req[0] = 0; wi_req = 0; wd_req = 0;
        tick();

        // Host write reached the other banks as well.
        enable = 1;
        ri_req[1] = 1; ri_data[1] = 32'd3;
        ri_req[3] = 1; ri_data[3] = 32'd4;
        tick();
        ri_req[1] = 0; ri_req[3] = 0;
        check("host_bank1", ro_data[1], 32'h55);
        check("host_bank3", ro_data[3], 32'h66);
        tick();

        // ---------------- reset with a pending result ----------------
        ro_ack[3] = 0;
        ri_req[3] = 1; ri_data[3] = 32'd10; ri_tag[3] = 3'd5;
        tick();
        ri_req[3] = 0;
        settle();
        check("pend_valid", 32'(ro_req[3]), 32'd1);
        check("pend_quiescent", 32'(quiescent), 32'd0);
        reset = 1;
        tick();
        reset = 0;
        settle();
        check("rst2_valid", 32'(ro_req[3]), 32'd0);
        check("rst2_quiescent", 32'(quiescent), 32'd1);
        ro_ack[3] = 1;
        ri_req[3] = 1; ri_data[3] = 32'd9;
        tick();
        ri_req[3] = 0;
        check("rst2_ram", ro_data[3], 32'hBEEF);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
